// File: rtl/sramlike_pkg.sv
// Shared definitions for the SRAM-like two-requester arbiter.
//   - FSM state encodings (IDLE / ADDR / DATA)
//   - owner encoding (INST / DATA requester)
//   - transfer size codes
//   - requester-side transaction struct used for the owner mux
package sramlike_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_ADDR = ST_ADDR,
    S_DATA = ST_DATA
  } state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic {
    O_INST = OWN_INST,
    O_DATA = OWN_DATA
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef struct packed {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sreq_t;

endpackage

// File: rtl/sramlike_rr_pick.sv
// Winner selection between the instruction and data requesters.
// Ports:
//   inst_req_i, data_req_i : pending requests
//   last_i                 : requester granted most recently
//   rr_mode_i              : 0 = data wins on contention, 1 = alternate
//   valid_o                : at least one request present
//   grant_o                : selected requester (meaningful when valid_o)
module sramlike_rr_pick
  import sramlike_pkg::*;
(
  input  logic   inst_req_i,
  input  logic   data_req_i,
  input  owner_e last_i,
  input  logic   rr_mode_i,
  output logic   valid_o,
  output owner_e grant_o
);

  always_comb begin
    valid_o = inst_req_i | data_req_i;
    grant_o = O_INST;
    if (data_req_i && !inst_req_i) begin
      grant_o = O_DATA;
    end else if (data_req_i && inst_req_i) begin
      if (rr_mode_i) grant_o = (last_i == O_INST) ? O_DATA : O_INST;
      else           grant_o = O_DATA;
    end
  end

endmodule

// File: rtl/sramlike_arbiter.sv
// Two-into-one arbiter for an SRAM-like bus (split address/data handshake).
// One transaction at a time is allowed on the shared m_* port. The winner
// is latched as owner in IDLE, its request is presented in ADDR, and the
// read/write completion is awaited in DATA. IDLE is always revisited between
// transactions. Read data is a pure pass-through; nothing is buffered.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   inst_* / data_* (in)           : requester req, wr, size, addr, wdata
//   inst_* / data_* (out)          : rdata, addr_ok, data_ok to requesters
//   m_req, m_wr, m_size, m_addr,
//   m_wdata (out)                  : shared-port request
//   m_rdata, m_addr_ok, m_data_ok  : shared-port response
// Parameter ROUND_ROBIN: 0 = data requester wins ties, 1 = alternate.
module sramlike_arbiter
  import sramlike_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  owner_e last_q,  last_d;

  sreq_t  inst_r, data_r, own_r;
  logic   pick_valid;
  owner_e pick_grant;
  logic   fwd_addr_ok, fwd_data_ok;

  assign inst_r = '{req: inst_req, wr: inst_wr, size: inst_size,
                    addr: inst_addr, wdata: inst_wdata};
  assign data_r = '{req: data_req, wr: data_wr, size: data_size,
                    addr: data_addr, wdata: data_wdata};
  assign own_r  = (owner_q == O_DATA) ? data_r : inst_r;

  sramlike_rr_pick u_pick (
    .inst_req_i (inst_req),
    .data_req_i (data_req),
    .last_i     (last_q),
    .rr_mode_i  (ROUND_ROBIN),
    .valid_o    (pick_valid),
    .grant_o    (pick_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= O_INST;
      last_q  <= O_INST;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    m_req       = 1'b0;
    m_wr        = 1'b0;
    m_size      = 2'b00;
    m_addr      = '0;
    m_wdata     = '0;
    fwd_addr_ok = 1'b0;
    fwd_data_ok = 1'b0;
    case (state_q)
      S_IDLE: begin
        // m_data_ok here is spurious and deliberately dropped.
        if (pick_valid) begin
          owner_d = pick_grant;
          last_d  = pick_grant;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        m_req       = own_r.req;
        m_wr        = own_r.wr;
        m_size      = own_r.size;
        m_addr      = own_r.addr;
        m_wdata     = own_r.wdata;
        fwd_addr_ok = m_addr_ok;
        // Slave may complete in the same cycle it accepts the address.
        fwd_data_ok = m_addr_ok & m_data_ok;
        if (m_addr_ok && m_data_ok) state_d = S_IDLE;
        else if (m_addr_ok)         state_d = S_DATA;
        else if (!own_r.req)        state_d = S_IDLE;  // requester withdrew
      end
      S_DATA: begin
        fwd_data_ok = m_data_ok;
        if (m_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are silenced for the whole reset cycle, whatever state we held.
    if (rst) begin
      m_req       = 1'b0;
      m_wr        = 1'b0;
      m_size      = 2'b00;
      m_addr      = '0;
      m_wdata     = '0;
      fwd_addr_ok = 1'b0;
      fwd_data_ok = 1'b0;
    end
  end

  assign inst_addr_ok = fwd_addr_ok & (owner_q == O_INST);
  assign inst_data_ok = fwd_data_ok & (owner_q == O_INST);
  assign data_addr_ok = fwd_addr_ok & (owner_q == O_DATA);
  assign data_data_ok = fwd_data_ok & (owner_q == O_DATA);

  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

endmodule

// File: tb/tb_sramlike_arbiter.sv
// Bench for sramlike_arbiter: a fixed-priority instance [0] and a
// round-robin instance [1] share the same stimulus.
module tb_sramlike_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata, m_rdata;
  logic        m_addr_ok, m_data_ok;

  logic [1:0][31:0] inst_rdata, data_rdata, m_addr, m_wdata;
  logic [1:0]       inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [1:0]       m_req, m_wr;
  logic [1:0][1:0]  m_size;

  int n_cmp = 0;
  int n_bad = 0;

  sramlike_arbiter #(.ROUND_ROBIN(1'b0)) u_fix (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata[0]),
    .inst_addr_ok(inst_addr_ok[0]), .inst_data_ok(inst_data_ok[0]),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata[0]),
    .data_addr_ok(data_addr_ok[0]), .data_data_ok(data_data_ok[0]),
    .m_req(m_req[0]), .m_wr(m_wr[0]), .m_size(m_size[0]), .m_addr(m_addr[0]),
    .m_wdata(m_wdata[0]), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok)
  );

  sramlike_arbiter #(.ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata[1]),
    .inst_addr_ok(inst_addr_ok[1]), .inst_data_ok(inst_data_ok[1]),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata[1]),
    .data_addr_ok(data_addr_ok[1]), .data_data_ok(data_data_ok[1]),
    .m_req(m_req[1]), .m_wr(m_wr[1]), .m_size(m_size[1]), .m_addr(m_addr[1]),
    .m_wdata(m_wdata[1]), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok)
  );

  task automatic drive_idle();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    m_rdata = 0; m_addr_ok = 0; m_data_ok = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    drive_idle();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
    data_addr = 32'h0000_0040; m_rdata = 32'hA5A5_0001;
    next_cycle();
    next_cycle();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({m_req[k], m_wr[k], m_size[k], m_addr[k], m_wdata[k]} !== 68'd0) begin
        n_bad++;
        $display("FAIL reset_bus[%0d]: got req=%b addr=%h, want all zero", k, m_req[k], m_addr[k]);
      end
      n_cmp++;
      if ({inst_addr_ok[k], inst_data_ok[k], data_addr_ok[k], data_data_ok[k]} !== 4'b0) begin
        n_bad++;
        $display("FAIL reset_hs[%0d]: got %b%b%b%b, want 0000", k,
                 inst_addr_ok[k], inst_data_ok[k], data_addr_ok[k], data_data_ok[k]);
      end
      n_cmp++;
      if (inst_rdata[k] !== 32'hA5A5_0001 || data_rdata[k] !== 32'hA5A5_0001) begin
        n_bad++;
        $display("FAIL rdata_pass[%0d]: got %h/%h, want a5a50001", k, inst_rdata[k], data_rdata[k]);
      end
    end
    rst = 1'b0;
    drive_idle();
    next_cycle();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({m_req[k], inst_addr_ok[k], inst_data_ok[k], data_addr_ok[k], data_data_ok[k]} !== 5'b0) begin
        n_bad++;
        $display("FAIL post_reset_idle[%0d]: got req=%b, want quiet", k, m_req[k]);
      end
    end
  endtask

  task automatic test_data_read();
    drive_idle();
    next_cycle();
    data_req = 1; data_wr = 0; data_size = 2'b10; data_addr = 32'h1000_0004;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (m_req[k] !== 1'b0) begin
        n_bad++; $display("FAIL read_c0_req[%0d]: got %b want 0", k, m_req[k]);
      end
    end
    next_cycle(); #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({m_req[k], m_wr[k], m_addr[k], data_addr_ok[k]} !== {1'b1, 1'b0, 32'h1000_0004, 1'b0}) begin
        n_bad++;
        $display("FAIL read_c1_addr[%0d]: got req=%b addr=%h aok=%b want 1/10000004/0",
                 k, m_req[k], m_addr[k], data_addr_ok[k]);
      end
    end
    next_cycle(); m_addr_ok = 1; #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({data_addr_ok[k], inst_addr_ok[k], data_data_ok[k], inst_data_ok[k]} !== 4'b1000) begin
        n_bad++;
        $display("FAIL read_c2_aok[%0d]: got %b%b%b%b want 1000", k,
                 data_addr_ok[k], inst_addr_ok[k], data_data_ok[k], inst_data_ok[k]);
      end
    end
    next_cycle(); data_req = 0; m_addr_ok = 0; #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({m_req[k], m_addr[k], data_data_ok[k]} !== 34'd0) begin
        n_bad++;
        $display("FAIL read_c3_wait[%0d]: got req=%b addr=%h dok=%b want 0", k, m_req[k], m_addr[k], data_data_ok[k]);
      end
    end
    next_cycle(); m_data_ok = 1; m_rdata = 32'hDEAD_BEEF; #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({data_data_ok[k], data_rdata[k], inst_data_ok[k], inst_addr_ok[k]} !== {1'b1, 32'hDEAD_BEEF, 2'b00}) begin
        n_bad++;
        $display("FAIL read_c4_dok[%0d]: got dok=%b rdata=%h iok=%b%b want 1/deadbeef/00",
                 k, data_data_ok[k], data_rdata[k], inst_addr_ok[k], inst_data_ok[k]);
      end
    end
    next_cycle(); m_data_ok = 0; #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({m_req[k], data_data_ok[k]} !== 2'b00) begin
        n_bad++; $display("FAIL read_c5_done[%0d]: got req=%b dok=%b want 00", k, m_req[k], data_data_ok[k]);
      end
    end
  endtask

  // Fixed priority on contention, then the inst grant after one idle cycle.
  // The inst transaction also exercises same-cycle addr_ok/data_ok and a
  // spurious data_ok in IDLE.
  task automatic test_priority();
    reset_dut();
    next_cycle();
    inst_req = 1; inst_addr = 32'h0000_0200; data_req = 1; data_addr = 32'h0000_0300;
    #1;
    n_cmp++;
    if (m_req[0] !== 1'b0) begin n_bad++; $display("FAIL prio_c0_req: got %b want 0", m_req[0]); end
    next_cycle(); m_addr_ok = 1; #1;
    n_cmp++;
    if ({m_req[0], m_addr[0], data_addr_ok[0], inst_addr_ok[0]} !== {1'b1, 32'h300, 2'b10}) begin
      n_bad++;
      $display("FAIL prio_c1_data_first: got req=%b addr=%h aok d/i=%b%b want 1/300/10",
               m_req[0], m_addr[0], data_addr_ok[0], inst_addr_ok[0]);
    end
    next_cycle(); data_req = 0; m_addr_ok = 0; m_data_ok = 1; #1;
    n_cmp++;
    if ({data_data_ok[0], inst_data_ok[0], m_req[0]} !== 3'b100) begin
      n_bad++;
      $display("FAIL prio_c2_dok: got dok d/i=%b%b req=%b want 10/0", data_data_ok[0], inst_data_ok[0], m_req[0]);
    end
    next_cycle(); m_data_ok = 0; #1;
    n_cmp++;
    if (m_req[0] !== 1'b0) begin n_bad++; $display("FAIL prio_c3_gap: got req=%b want 0", m_req[0]); end
    next_cycle(); #1;
    n_cmp++;
    if ({m_req[0], m_addr[0]} !== {1'b1, 32'h200}) begin
      n_bad++; $display("FAIL prio_c4_inst: got req=%b addr=%h want 1/200", m_req[0], m_addr[0]);
    end
    m_addr_ok = 1; m_data_ok = 1; #1;
    n_cmp++;
    if ({inst_addr_ok[0], inst_data_ok[0], data_addr_ok[0], data_data_ok[0]} !== 4'b1100) begin
      n_bad++;
      $display("FAIL both_ok_same_cycle: got %b%b%b%b want 1100",
               inst_addr_ok[0], inst_data_ok[0], data_addr_ok[0], data_data_ok[0]);
    end
    next_cycle(); m_addr_ok = 0; m_data_ok = 1; #1;
    n_cmp++;
    if ({m_req[0], inst_data_ok[0], data_data_ok[0]} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_after_both_ok: got req=%b dok i/d=%b%b want 000", m_req[0], inst_data_ok[0], data_data_ok[0]);
    end
    next_cycle(); m_data_ok = 0; #1;
    n_cmp++;
    if (m_req[0] !== 1'b1) begin n_bad++; $display("FAIL regrant_after_idle: got req=%b want 1", m_req[0]); end
    m_addr_ok = 1; m_data_ok = 1;
    next_cycle();
    drive_idle();
    next_cycle();
  endtask

  task automatic test_write_mux();
    drive_idle();
    next_cycle();
    inst_req = 1; inst_wr = 1; inst_size = 2'b10; inst_addr = 32'h0000_0100;
    inst_wdata = 32'h1234_5678; data_wr = 1; data_size = 2'b01;
    data_addr = 32'hFFFF_0000; data_wdata = 32'h0BAD_F00D;
    next_cycle(); #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({m_req[k], m_wr[k], m_size[k], m_addr[k], m_wdata[k]} !==
          {1'b1, 1'b1, 2'b10, 32'h0000_0100, 32'h1234_5678}) begin
        n_bad++;
        $display("FAIL write_mux[%0d]: got req=%b wr=%b size=%b addr=%h wdata=%h want 1/1/10/100/12345678",
                 k, m_req[k], m_wr[k], m_size[k], m_addr[k], m_wdata[k]);
      end
    end
    m_addr_ok = 1; #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({inst_addr_ok[k], data_addr_ok[k], inst_data_ok[k]} !== 3'b100) begin
        n_bad++;
        $display("FAIL write_aok[%0d]: got %b%b%b want 100", k, inst_addr_ok[k], data_addr_ok[k], inst_data_ok[k]);
      end
    end
    next_cycle(); inst_req = 0; m_addr_ok = 0; m_data_ok = 1; #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({m_req[k], m_wr[k], m_size[k], m_addr[k], m_wdata[k], inst_data_ok[k], data_data_ok[k]} !==
          {68'd0, 2'b10}) begin
        n_bad++;
        $display("FAIL write_data_phase[%0d]: got req=%b wr=%b addr=%h dok i/d=%b%b want zeros/10",
                 k, m_req[k], m_wr[k], m_addr[k], inst_data_ok[k], data_data_ok[k]);
      end
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_reset_mid();
    drive_idle();
    next_cycle();
    data_req = 1; data_addr = 32'h0000_0040;
    next_cycle(); m_addr_ok = 1;
    next_cycle(); data_req = 0; m_addr_ok = 0; rst = 1; m_data_ok = 1; #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({data_data_ok[k], inst_data_ok[k], m_req[k]} !== 3'b000) begin
        n_bad++;
        $display("FAIL rst_in_data[%0d]: got dok d/i=%b%b want 00", k, data_data_ok[k], inst_data_ok[k]);
      end
    end
    next_cycle(); rst = 0; m_data_ok = 1; #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({data_data_ok[k], inst_data_ok[k], m_req[k]} !== 3'b000) begin
        n_bad++;
        $display("FAIL after_rst_dok[%0d]: got dok d/i=%b%b req=%b want 000",
                 k, data_data_ok[k], inst_data_ok[k], m_req[k]);
      end
    end
    next_cycle();
    drive_idle();
  endtask

  // Both requesters busy forever; record which one appears on m_addr.
  task automatic test_alternate();
    logic [31:0] got0[$];
    logic [31:0] got1[$];
    logic [31:0] want0[4];
    logic [31:0] want1[4];
    want0 = '{32'hDDDD_0000, 32'hDDDD_0000, 32'hDDDD_0000, 32'hDDDD_0000};
    want1 = '{32'hDDDD_0000, 32'h1111_0000, 32'hDDDD_0000, 32'h1111_0000};
    reset_dut();
    inst_req = 1; data_req = 1; inst_addr = 32'h1111_0000; data_addr = 32'hDDDD_0000;
    m_addr_ok = 1; m_data_ok = 1;
    for (int c = 0; c < 40 && (got0.size() < 4 || got1.size() < 4); c++) begin
      next_cycle(); #1;
      if (m_req[0] && got0.size() < 4) got0.push_back(m_addr[0]);
      if (m_req[1] && got1.size() < 4) got1.push_back(m_addr[1]);
    end
    n_cmp++;
    if (got0.size() != 4 || got1.size() != 4) begin
      n_bad++;
      $display("FAIL alternate_timeout: got %0d/%0d grants want 4/4", got0.size(), got1.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (got0[i] !== want0[i]) begin
          n_bad++; $display("FAIL fixed_order[%0d]: got %h want %h", i, got0[i], want0[i]);
        end
        n_cmp++;
        if (got1[i] !== want1[i]) begin
          n_bad++; $display("FAIL rr_order[%0d]: got %h want %h", i, got1[i], want1[i]);
        end
      end
    end
    drive_idle();
    next_cycle();
  endtask

  // Transaction-level reference: phase 0 = no owner, 1 = address offered,
  // 2 = awaiting completion.
  int phase[2];
  int owner[2];
  int last_g[2];

  task automatic test_random();
    logic [67:0] want_bus, got_bus;
    logic [3:0]  want_hs, got_hs;
    logic        oreq, aok, dok;
    int          w;
    reset_dut();
    for (int k = 0; k < 2; k++) begin phase[k] = 0; owner[k] = 0; last_g[k] = 0; end
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      rst        = ($urandom_range(0, 99) == 0);
      inst_req   = ($urandom_range(0, 9) < 7);
      data_req   = ($urandom_range(0, 9) < 7);
      inst_wr    = $urandom_range(0, 1);
      data_wr    = $urandom_range(0, 1);
      inst_size  = 2'($urandom_range(0, 2));
      data_size  = 2'($urandom_range(0, 2));
      inst_addr  = $urandom;
      data_addr  = $urandom;
      inst_wdata = $urandom;
      data_wdata = $urandom;
      m_rdata    = $urandom;
      m_addr_ok  = ($urandom_range(0, 1) == 1);
      m_data_ok  = ($urandom_range(0, 9) < 4);
      #1;
      for (int k = 0; k < 2; k++) begin
        oreq = (owner[k] == 1) ? data_req : inst_req;
        want_bus = '0;
        aok = 0;
        dok = 0;
        if (!rst && phase[k] == 1) begin
          want_bus = (owner[k] == 1) ? {data_req, data_wr, data_size, data_addr, data_wdata}
                                     : {inst_req, inst_wr, inst_size, inst_addr, inst_wdata};
          aok = m_addr_ok;
          dok = m_addr_ok && m_data_ok;
        end else if (!rst && phase[k] == 2) begin
          dok = m_data_ok;
        end
        want_hs = (owner[k] == 1) ? {2'b00, aok, dok} : {aok, dok, 2'b00};
        got_bus = {m_req[k], m_wr[k], m_size[k], m_addr[k], m_wdata[k]};
        got_hs  = {inst_addr_ok[k], inst_data_ok[k], data_addr_ok[k], data_data_ok[k]};
        n_cmp++;
        if (got_bus !== want_bus || got_hs !== want_hs) begin
          n_bad++;
          $display("FAIL rand_outputs[%0d] cyc %0d: got bus=%h hs=%b want bus=%h hs=%b",
                   k, c, got_bus, got_hs, want_bus, want_hs);
        end
        n_cmp++;
        if (inst_rdata[k] !== m_rdata || data_rdata[k] !== m_rdata) begin
          n_bad++;
          $display("FAIL rand_rdata[%0d] cyc %0d: got %h/%h want %h", k, c, inst_rdata[k], data_rdata[k], m_rdata);
        end
        if (rst) begin
          phase[k] = 0; owner[k] = 0; last_g[k] = 0;
        end else if (phase[k] == 0) begin
          if (inst_req || data_req) begin
            if (inst_req && data_req) w = (k == 1) ? 1 - last_g[k] : 1;
            else                      w = data_req ? 1 : 0;
            owner[k] = w; last_g[k] = w; phase[k] = 1;
          end
        end else if (phase[k] == 1) begin
          if (m_addr_ok && m_data_ok) phase[k] = 0;
          else if (m_addr_ok)         phase[k] = 2;
          else if (!oreq)             phase[k] = 0;
        end else if (m_data_ok) begin
          phase[k] = 0;
        end
      end
    end
    rst = 0;
    drive_idle();
    next_cycle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_data_read();
    test_priority();
    test_write_mux();
    test_reset_mid();
    test_alternate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
